// File: rtl/rv32_mc_core.sv
// Multi-cycle RV32I/RV32E core with handshaked instruction and data ports,
// byte-enable stores and precise halting on ECALL/EBREAK or faults.
module rv32_mc_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        retire,
   output logic        halted,
   output logic        trap,
   output logic [2:0]  trap_cause,
   output logic [31:0] trap_pc
);
   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                          OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                          OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;
   localparam logic [5:0] NREG = 6'(NUM_REGS);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d;
   logic        imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
   logic [3:0]  dmem_be_q, dmem_be_d;
   logic [31:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
   logic        halted_q, halted_d, trap_q, trap_d;
   logic [2:0]  cause_q, cause_d, fault;
   logic [31:0] trap_pc_q, trap_pc_d;
   logic [31:0] rf_q [32];
   logic        rf_we, retire_c;
   logic [31:0] rf_wdata;

   logic [6:0]  opcode, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_v, rs2_v, op_b, alu, wb, next_pc, ea;
   logic        legal, is_halt, use_rs1, use_rs2, use_rd, taken, jump, reg_bad, misal;
   logic        is_mem, is_store;

   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [2:0] fn);
      logic [31:0] s;
      s = word >> {lane, 3'b000};
      case (fn)
         3'b000:  return {{24{s[7]}}, s[7:0]};
         3'b001:  return {{16{s[15]}}, s[15:0]};
         3'b100:  return {24'b0, s[7:0]};
         3'b101:  return {16'b0, s[15:0]};
         default: return s;
      endcase
   endfunction

   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign f3     = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign f7     = ir_q[31:25];
   assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign imm_u  = {ir_q[31:12], 12'b0};
   assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
   assign rs1_v  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
   assign rs2_v  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

   // Legality and which register fields the instruction actually uses.
   always_comb begin
      legal = 1'b0; is_halt = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL: begin legal = 1'b1; use_rd = 1'b1; end
         OP_JALR: begin legal = (f3 == 3'd0); use_rs1 = 1'b1; use_rd = 1'b1; end
         OP_BR:   begin legal = (f3 != 3'd2) && (f3 != 3'd3); use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_LD:   begin legal = (f3 != 3'd3) && (f3 < 3'd6); use_rs1 = 1'b1; use_rd = 1'b1; end
         OP_ST:   begin legal = (f3 < 3'd3); use_rs1 = 1'b1; use_rs2 = 1'b1; end
         OP_IMM: begin
            legal   = (f3 == 3'd1) ? (f7 == 7'h00) :
                      (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            use_rs1 = 1'b1; use_rd = 1'b1;
         end
         OP_REG: begin
            legal   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
         end
         OP_FENCE: legal = 1'b1;
         OP_SYS: begin
            is_halt = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073);
            legal   = is_halt;
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      alu  = '0;
      op_b = (opcode == OP_REG) ? rs2_v : imm_i;
      case (f3)
         3'd0: alu = (opcode == OP_REG && ir_q[30]) ? rs1_v - op_b : rs1_v + op_b;
         3'd1: alu = rs1_v << op_b[4:0];
         3'd2: alu = {31'b0, $signed(rs1_v) < $signed(op_b)};
         3'd3: alu = {31'b0, rs1_v < op_b};
         3'd4: alu = rs1_v ^ op_b;
         3'd5: alu = ir_q[30] ? 32'($signed(rs1_v) >>> op_b[4:0]) : rs1_v >> op_b[4:0];
         3'd6: alu = rs1_v | op_b;
         default: alu = rs1_v & op_b;
      endcase
      case (f3)
         3'd0: taken = (rs1_v == rs2_v);
         3'd1: taken = (rs1_v != rs2_v);
         3'd4: taken = $signed(rs1_v) < $signed(rs2_v);
         3'd5: taken = $signed(rs1_v) >= $signed(rs2_v);
         3'd6: taken = rs1_v < rs2_v;
         3'd7: taken = rs1_v >= rs2_v;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      wb      = alu;
      next_pc = pc_q + 32'd4;
      jump    = 1'b0;
      case (opcode)
         OP_LUI:   wb = imm_u;
         OP_AUIPC: wb = pc_q + imm_u;
         OP_JAL:   begin wb = pc_q + 32'd4; next_pc = pc_q + imm_j; jump = 1'b1; end
         OP_JALR:  begin wb = pc_q + 32'd4; next_pc = (rs1_v + imm_i) & ~32'd1; jump = 1'b1; end
         OP_BR:    if (taken) begin next_pc = pc_q + imm_b; jump = 1'b1; end
         default:  wb = alu;
      endcase
      is_store = (opcode == OP_ST);
      is_mem   = is_store || (opcode == OP_LD);
      ea       = rs1_v + (is_store ? imm_s : imm_i);
      misal    = ((f3[1:0] == 2'd1) && ea[0]) || ((f3[1:0] == 2'd2) && (ea[1:0] != 2'd0));
      reg_bad  = (use_rs1 && ({1'b0, rs1} >= NREG)) || (use_rs2 && ({1'b0, rs2} >= NREG)) ||
                 (use_rd && ({1'b0, rd} >= NREG));
      if (!legal)                                fault = 3'd1;
      else if (reg_bad)                          fault = 3'd4;
      else if (jump && next_pc[1:0] != 2'd0)     fault = 3'd2;
      else if (is_mem && misal)                  fault = 3'd3;
      else                                       fault = 3'd0;
   end

   always_comb begin
      state_d = state_q; pc_d = pc_q; ir_d = ir_q;
      imem_req_d = imem_req_q; dmem_req_d = dmem_req_q; dmem_we_d = dmem_we_q;
      dmem_be_d = dmem_be_q; dmem_addr_d = dmem_addr_q; dmem_wdata_d = dmem_wdata_q;
      halted_d = halted_q; trap_d = trap_q; cause_d = cause_q; trap_pc_d = trap_pc_q;
      rf_we = 1'b0; rf_wdata = wb; retire_c = 1'b0;
      case (state_q)
         FETCH: begin
            // The request register is low in the first cycle out of reset.
            if (imem_req_q && imem_ready) begin
               ir_d = imem_rdata; imem_req_d = 1'b0; state_d = EXEC;
            end else begin
               imem_req_d = 1'b1;
            end
         end
         EXEC: begin
            if (fault != 3'd0) begin
               halted_d = 1'b1; trap_d = 1'b1; cause_d = fault; trap_pc_d = pc_q; state_d = HALT;
            end else if (is_halt) begin
               halted_d = 1'b1; trap_pc_d = pc_q; state_d = HALT;
            end else if (is_mem) begin
               dmem_req_d = 1'b1; dmem_we_d = is_store; dmem_addr_d = ea; state_d = MEM;
               dmem_be_d  = 4'b0000;
               if (is_store) begin
                  case (f3[1:0])
                     2'd0: begin dmem_be_d = 4'b0001 << ea[1:0]; dmem_wdata_d = {4{rs2_v[7:0]}}; end
                     2'd1: begin dmem_be_d = ea[1] ? 4'b1100 : 4'b0011; dmem_wdata_d = {2{rs2_v[15:0]}}; end
                     default: begin dmem_be_d = 4'b1111; dmem_wdata_d = rs2_v; end
                  endcase
               end
            end else begin
               rf_we = use_rd; pc_d = next_pc; retire_c = 1'b1; imem_req_d = 1'b1; state_d = FETCH;
            end
         end
         MEM: begin
            if (dmem_ready) begin
               rf_we      = ~dmem_we_q;
               rf_wdata   = load_ext(dmem_rdata, dmem_addr_q[1:0], f3);
               dmem_req_d = 1'b0; retire_c = 1'b1; pc_d = pc_q + 32'd4;
               imem_req_d = 1'b1; state_d = FETCH;
            end
         end
         default: state_d = HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH; pc_q <= RESET_PC; ir_q <= '0;
         imem_req_q <= 1'b0; dmem_req_q <= 1'b0; dmem_we_q <= 1'b0; dmem_be_q <= '0;
         dmem_addr_q <= '0; dmem_wdata_q <= '0;
         halted_q <= 1'b0; trap_q <= 1'b0; cause_q <= '0; trap_pc_q <= '0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d; pc_q <= pc_d; ir_q <= ir_d;
         imem_req_q <= imem_req_d; dmem_req_q <= dmem_req_d; dmem_we_q <= dmem_we_d;
         dmem_be_q <= dmem_be_d; dmem_addr_q <= dmem_addr_d; dmem_wdata_q <= dmem_wdata_d;
         halted_q <= halted_d; trap_q <= trap_d; cause_q <= cause_d; trap_pc_q <= trap_pc_d;
         if (rf_we && rd != 5'd0) rf_q[rd] <= rf_wdata;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_be    = dmem_be_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign retire     = retire_c;
   assign halted     = halted_q;
   assign trap       = trap_q;
   assign trap_cause = cause_q;
   assign trap_pc    = trap_pc_q;
endmodule

// File: tb/tb_rv32_mc_core.sv
// Directed bench for rv32_mc_core: small programs in a behavioural memory model,
// observed through stores (scoreboard), retire pulses and halt/trap status.
module tb_rv32_mc_core;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        imem_req, imem_ready = 1'b0, dmem_req, dmem_we, dmem_ready = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0, dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic [3:0]  dmem_be;
   logic        retire, halted, trap;
   logic [2:0]  trap_cause;
   logic [31:0] trap_pc;

   rv32_mc_core #(.RESET_PC(32'h0000_0200), .NUM_REGS(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .retire(retire), .halted(halted), .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc));

   // RV32E instance fed a constant ADD x17,x1,x2 with zero-wait memories.
   localparam logic [31:0] ADD17 = {7'h00, 5'd2, 5'd1, 3'd0, 5'd17, 7'b0110011};
   logic        imem_req_e, dmem_req_e, dmem_we_e, retire_e, halted_e, trap_e;
   logic [31:0] imem_addr_e, dmem_addr_e, dmem_wdata_e, trap_pc_e;
   logic [3:0]  dmem_be_e;
   logic [2:0]  trap_cause_e;
   rv32_mc_core #(.RESET_PC(32'h0000_0000), .NUM_REGS(16)) dut_e (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req_e), .imem_addr(imem_addr_e), .imem_ready(imem_req_e), .imem_rdata(ADD17),
      .dmem_req(dmem_req_e), .dmem_we(dmem_we_e), .dmem_be(dmem_be_e), .dmem_addr(dmem_addr_e),
      .dmem_wdata(dmem_wdata_e), .dmem_ready(dmem_req_e), .dmem_rdata(32'h0),
      .retire(retire_e), .halted(halted_e), .trap(trap_e), .trap_cause(trap_cause_e),
      .trap_pc(trap_pc_e));

   int checks = 0, errors = 0;
   int cyc = 0, ret_cnt = 0, ret_base = 0, dreq_cnt = 0, imem_ws = 0, dmem_ws = 0, icnt = 0, dcnt = 0;
   int rcyc[$];
   logic [67:0] exp_q[$];
   logic [67:0] got;
   logic [31:0] imem [256];
   logic [31:0] dmem [256];

   task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] e_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
      logic [31:0] v; v = imm;
      return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction
   function automatic logic [31:0] e_s(int imm, int rs2, int rs1, int f3);
      logic [31:0] v; v = imm;
      return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] e_b(int imm, int rs2, int rs1, int f3);
      logic [31:0] v; v = imm;
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] e_r(int f7, int rs2, int rs1, int f3, int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
   endfunction
   function automatic logic [31:0] e_u(int imm, int rd);
      logic [31:0] v; v = imm;
      return {v[19:0], 5'(rd), 7'b0110111};
   endfunction
   function automatic logic [31:0] e_j(int imm, int rd);
      logic [31:0] v; v = imm;
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
   endfunction
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [6:0]  OPI = 7'b0010011, OPL = 7'b0000011;

   task automatic put(input logic [31:0] a, input logic [31:0] ins);
      imem[a[9:2]] = ins;
   endtask
   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin imem[i] = '0; dmem[i] = '0; end
   endtask
   task automatic exp_st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      exp_q.push_back({a, be, d});
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      rcyc.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ret_base = ret_cnt;
   endtask
   task automatic wait_halt(input int limit);
      int n = 0;
      while (halted !== 1'b1 && n < limit) begin @(negedge clk); n++; end
      chk("halt_reached", halted, 1);
   endtask
   task automatic end_prog(input string tag, input logic t, input logic [2:0] c,
                           input logic [31:0] tpc, input int nret);
      repeat (3) @(negedge clk);
      chk({tag, "_trap"}, trap, t);
      chk({tag, "_cause"}, trap_cause, c);
      chk({tag, "_trap_pc"}, trap_pc, tpc);
      chk({tag, "_retired"}, ret_cnt - ret_base, nret);
      chk({tag, "_reqs_low"}, {imem_req, dmem_req}, 2'b00);
      chk({tag, "_stores_left"}, exp_q.size(), 0);
   endtask

   // Memory models: update ready/rdata just after the rising edge.
   always begin
      @(posedge clk); #1;
      if (!rst_n || imem_ready) begin imem_ready = 1'b0; icnt = 0; end
      else if (imem_req) begin
         if (icnt == imem_ws) begin imem_ready = 1'b1; imem_rdata = imem[imem_addr[9:2]]; end
         else icnt++;
      end else icnt = 0;
   end
   always begin
      @(posedge clk); #1;
      if (!rst_n || dmem_ready) begin dmem_ready = 1'b0; dcnt = 0; end
      else if (dmem_req) begin
         if (dcnt == dmem_ws) begin
            dmem_ready = 1'b1;
            dmem_rdata = dmem[dmem_addr[9:2]];
            if (dmem_we)
               for (int b = 0; b < 4; b++)
                  if (dmem_be[b]) dmem[dmem_addr[9:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
         end else dcnt++;
      end else dcnt = 0;
   end

   always @(negedge clk) begin
      cyc++;
      if (dmem_req) dreq_cnt++;
      if (rst_n && retire) begin ret_cnt++; rcyc.push_back(cyc); end
      if (rst_n && dmem_req && dmem_ready && dmem_we) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL store_unexpected: observed %0h expected none", {dmem_addr, dmem_be, dmem_wdata});
         end
         if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            chk("store", {dmem_addr, dmem_be, dmem_wdata}, got);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, base;
      // Wait states: ADDI, ADDI, then store x2 for observation.
      clear_mem();
      put(32'h200, e_i(5, 0, 0, 1, OPI));
      put(32'h204, e_i(-7, 1, 0, 2, OPI));
      put(32'h208, e_s(0, 2, 0, 2));
      put(32'h20C, ECALL);
      exp_st(32'h0, 4'hF, 32'hFFFF_FFFE);
      imem_ws = 3;
      #12;
      chk("rst_imem_req", imem_req, 0);
      chk("rst_dmem_req", {dmem_req, dmem_we, dmem_be}, 0);
      chk("rst_status", {retire, halted, trap, trap_cause}, 0);
      chk("rst_trap_pc", trap_pc, 0);
      chk("rst_imem_addr", imem_addr, 32'h200);
      chk("rst_dmem_bus", {dmem_addr, dmem_wdata}, 0);
      @(negedge clk); rst_n = 1'b1; ret_base = ret_cnt;
      @(negedge clk);
      chk("first_fetch", {imem_req, imem_addr}, {1'b1, 32'h200});
      wait_halt(200);
      chk("ws_interval", (rcyc.size() >= 2) ? rcyc[1] - rcyc[0] : -1, 2 + 3);
      end_prog("waits", 1'b0, 3'd0, 32'h20C, 3);
      chk("rv32e_trap", {halted_e, trap_e, trap_cause_e, retire_e}, {1'b1, 1'b1, 3'd4, 1'b0});

      // Byte/halfword stores and sign/zero-extending byte loads.
      clear_mem(); imem_ws = 0; dmem_ws = 2;
      put(32'h200, e_i(32'h100, 0, 0, 1, OPI));
      put(32'h204, e_u(32'h80000, 2));
      put(32'h208, e_i(32'hA5, 2, 0, 2, OPI));
      put(32'h20C, e_s(3, 2, 1, 0));
      put(32'h210, e_i(3, 1, 0, 3, OPL));
      put(32'h214, e_i(3, 1, 4, 4, OPL));
      put(32'h218, e_s(0, 3, 1, 2));
      put(32'h21C, e_s(4, 4, 1, 2));
      put(32'h220, e_s(6, 2, 1, 1));
      put(32'h224, ECALL);
      exp_st(32'h103, 4'b1000, 32'hA5A5_A5A5);
      exp_st(32'h100, 4'hF, 32'hFFFF_FFA5);
      exp_st(32'h104, 4'hF, 32'h0000_00A5);
      exp_st(32'h106, 4'b1100, 32'h00A5_00A5);
      do_reset();
      wait_halt(300);
      end_prog("bytes", 1'b0, 3'd0, 32'h224, 9);

      // Branches, JALR, SLT/SUB/SRAI and a write to x17.
      clear_mem(); dmem_ws = 0;
      put(32'h200, e_i(-1, 0, 0, 1, OPI));
      put(32'h204, e_i(1, 0, 0, 2, OPI));
      put(32'h208, e_b(8, 2, 1, 4));
      put(32'h20C, e_i(1, 0, 0, 6, OPI));
      put(32'h210, e_b(8, 2, 1, 6));
      put(32'h214, e_i(2, 0, 0, 7, OPI));
      put(32'h218, e_r(0, 2, 1, 2, 8));
      put(32'h21C, e_r(32'h20, 1, 2, 0, 10));
      put(32'h220, e_i(32'h41, 0, 0, 5, 7'b1100111));
      put(32'h040, e_s(0, 6, 0, 2));
      put(32'h044, e_s(4, 7, 0, 2));
      put(32'h048, e_s(8, 8, 0, 2));
      put(32'h04C, e_s(12, 10, 0, 2));
      put(32'h050, e_s(16, 5, 0, 2));
      put(32'h054, e_i(7, 0, 0, 1, OPI));
      put(32'h058, e_r(0, 2, 1, 0, 17));
      put(32'h05C, e_s(20, 17, 0, 2));
      put(32'h060, e_u(32'h80000, 12));
      put(32'h064, e_i(32'h404, 12, 5, 13, OPI));
      put(32'h068, e_s(24, 13, 0, 2));
      put(32'h06C, ECALL);
      exp_st(32'd0, 4'hF, 32'd0);
      exp_st(32'd4, 4'hF, 32'd2);
      exp_st(32'd8, 4'hF, 32'd1);
      exp_st(32'd12, 4'hF, 32'd2);
      exp_st(32'd16, 4'hF, 32'h224);
      exp_st(32'd20, 4'hF, 32'd8);
      exp_st(32'd24, 4'hF, 32'hF800_0000);
      do_reset();
      wait_halt(300);
      end_prog("branch", 1'b0, 3'd0, 32'h06C, 19);

      // Misaligned word load never reaches the bus.
      clear_mem();
      put(32'h200, e_i(32'h100, 0, 0, 1, OPI));
      put(32'h204, e_i(2, 1, 2, 3, OPL));
      do_reset();
      base = dreq_cnt;
      wait_halt(100);
      chk("misal_no_dreq", dreq_cnt - base, 0);
      end_prog("misal", 1'b1, 3'd3, 32'h204, 1);

      // Misaligned JAL target and an illegal opcode.
      clear_mem();
      put(32'h200, e_j(6, 1));
      do_reset();
      wait_halt(100);
      end_prog("jal_misal", 1'b1, 3'd2, 32'h200, 0);
      clear_mem();
      put(32'h200, 32'hFFFF_FFFF);
      do_reset();
      wait_halt(100);
      end_prog("illegal", 1'b1, 3'd1, 32'h200, 0);

      // Reset asserted while a load is stalled on the data port.
      clear_mem(); dmem_ws = 40;
      put(32'h200, e_i(0, 0, 2, 1, OPL));
      put(32'h204, ECALL);
      do_reset();
      n = 0;
      while (dmem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("stall_dmem_req", dmem_req, 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_reqs", {imem_req, dmem_req, retire}, 3'b000);
      chk("async_rst_pc", imem_addr, 32'h200);
      dmem_ws = 0;
      @(negedge clk); rst_n = 1'b1; ret_base = ret_cnt;
      @(negedge clk);
      chk("refetch", {imem_req, imem_addr}, {1'b1, 32'h200});
      wait_halt(100);
      end_prog("rst_resume", 1'b0, 3'd0, 32'h204, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
